// File: rtl/window_column_serializer.sv
// rtl/window_column_serializer.sv - raster stream to serial vertical columns for the 5x5 window buffer
module window_column_serializer #(
    parameter int DataBitWidth = 12,
    parameter int FilterSize   = 5,
    parameter int ImgWidth     = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [DataBitWidth-1:0] pix_in,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    input  logic                           frame_start,
    output logic signed [DataBitWidth-1:0] d_out,
    output logic                           en,
    output logic                           win_valid
);
    localparam int ColW  = (ImgWidth > 1) ? $clog2(ImgWidth) : 1;
    localparam int CntW  = (FilterSize > 1) ? $clog2(FilterSize) : 1;
    localparam int Lines = FilterSize - 1;
    localparam logic [ColW-1:0] ColLast      = ColW'(ImgWidth - 1);
    localparam logic [ColW-1:0] ColFirstFull = ColW'(FilterSize - 1);
    localparam logic [CntW-1:0] KLast        = CntW'(FilterSize - 1);

    typedef enum logic {IDLE, EMIT} state_e;
    typedef logic signed [DataBitWidth-1:0] pix_t;

    state_e          state_q, state_d;
    logic [CntW-1:0] k_q, k_d, k_inc;
    logic [ColW-1:0] col_q, col_d, col_eff;
    logic [CntW-1:0] row_q, row_d, row_eff;
    logic            win_ok_q, win_ok_d;
    pix_t            d_out_q, d_out_d;
    logic            en_q, en_d;
    logic            win_q, win_d;
    logic            accept, start;

    pix_t line_q   [Lines][ImgWidth];
    pix_t colreg_q [FilterSize];
    pix_t new_col  [FilterSize];

    assign pix_ready = (state_q == IDLE) || (state_q == EMIT && k_q == KLast);
    assign accept    = pix_valid && pix_ready;
    assign k_inc     = k_q + CntW'(1);

    // frame_start forces the accepted pixel to row 0, col 0
    always_comb begin
        col_eff = frame_start ? '0 : col_q;
        row_eff = frame_start ? '0 : row_q;
        for (int j = 0; j < Lines; j++) begin
            new_col[j] = line_q[j][col_eff];
        end
        new_col[Lines] = pix_in;
    end

    assign start = accept && (row_eff == KLast);

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        state_d  = state_q;
        k_d      = k_q;
        win_ok_d = win_ok_q;
        d_out_d  = d_out_q;
        en_d     = 1'b0;
        win_d    = 1'b0;
        if (accept) begin
            if (col_eff == ColLast) begin
                col_d = '0;
                row_d = (row_eff == KLast) ? row_eff : row_eff + CntW'(1);
            end else begin
                col_d = col_eff + ColW'(1);
                row_d = row_eff;
            end
        end
        if (start) begin
            state_d  = EMIT;
            k_d      = '0;
            en_d     = 1'b1;
            d_out_d  = new_col[0];
            win_ok_d = (col_eff >= ColFirstFull);
        end else if (state_q == EMIT && k_q != KLast) begin
            k_d     = k_inc;
            en_d    = 1'b1;
            d_out_d = colreg_q[k_inc];
            win_d   = win_ok_q && (k_inc == KLast);
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            win_ok_q <= 1'b0;
            d_out_q  <= '0;
            en_q     <= 1'b0;
            win_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            col_q    <= col_d;
            row_q    <= row_d;
            win_ok_q <= win_ok_d;
            d_out_q  <= d_out_d;
            en_q     <= en_d;
            win_q    <= win_d;
        end
    end

    // Line memories shift upward one row per accepted pixel at its column
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < Lines; j++) begin
                for (int c = 0; c < ImgWidth; c++) begin
                    line_q[j][c] <= '0;
                end
            end
            for (int k = 0; k < FilterSize; k++) begin
                colreg_q[k] <= '0;
            end
        end else if (accept) begin
            for (int j = 0; j < Lines - 1; j++) begin
                line_q[j][col_eff] <= line_q[j+1][col_eff];
            end
            line_q[Lines-1][col_eff] <= pix_in;
            for (int k = 0; k < FilterSize; k++) begin
                colreg_q[k] <= new_col[k];
            end
        end
    end

    assign d_out     = d_out_q;
    assign en        = en_q;
    assign win_valid = win_q;
endmodule

// File: doc/window_column_serializer.md
Name: window_column_serializer

Overview:
Upstream feeder for the 5x5 serial window buffer. It accepts a raster-order pixel stream and stores the previous FilterSize-1 image lines. For each pixel of row >= FilterSize-1, it emits the full vertical column (oldest row first) as FilterSize consecutive en-qualified words. This matches the window buffer's round-robin row loading, so its row-select phase always stays aligned.

Parameters:
DataBitWidth, 12, pixel width (signed)
FilterSize, 5, window height; also the number of words emitted per column
ImgWidth, 32, pixels per image line; the column counter is clog2(ImgWidth) bits wide

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
pix_in  in  DataBitWidth  signed raster pixel
pix_valid  in  1  pix_in is valid
pix_ready  out  1  block can accept pix_in this cycle
frame_start  in  1  qualifies the accepted pixel as row 0, col 0 of a new frame
d_out  out  DataBitWidth  signed column element to the window buffer
en  out  1  d_out valid; drives the window buffer en
win_valid  out  1  window in the buffer is complete after this cycle's edge

Behaviour:
- Reset (rst high at posedge):
  - state IDLE; col, row, k cleared; all line memories and the column register cleared to 0.
  - d_out=0, en=0, win_valid=0; pix_ready=1 from the cycle after reset.
  - Applies mid-emission: en drops the cycle after rst. The window buffer shares rst, so both restart with phase at row 0.
- Accept condition: pix_valid && pix_ready at posedge. While pix_ready=0, pix_valid is ignored and the source holds its data.
- pix_ready = (state==IDLE) || (state==EMIT && k==FilterSize-1). This allows back-to-back columns with no bubble.
- Line memories: FilterSize-1 lines (line[0] oldest to line[FilterSize-2] newest), each ImgWidth words, held in flops.
  - On accept at column c: line[j][c] <= line[j+1][c] for j < FilterSize-2, and line[FilterSize-2][c] <= pix_in.
- Column capture on accept: colreg <= {line[0][c], ..., line[FilterSize-2][c], pix_in}, using pre-update memory values.
- Counters on accept:
  - col increments and wraps ImgWidth-1 -> 0.
  - On wrap, row increments, saturating at FilterSize-1.
  - If frame_start=1, the accepted pixel is treated as col=0, row=0: after the accept, col=1 and row=0. Memories are not cleared; priming repeats.
- FSM:
  - IDLE: on accept with row==FilterSize-1 (primed), go to EMIT with k=0. On accept with row<FilterSize-1, store only and stay in IDLE.
  - EMIT: en=1 and d_out=colreg[k] (k=0 is the oldest row). k increments each cycle.
  - At k==FilterSize-1: if a new primed accept occurs, k returns to 0 and EMIT continues. Otherwise go to IDLE.
- Latency: a pixel accepted at edge T produces en high on cycles T+1..T+FilterSize. The pixel itself appears at T+FilterSize.
- d_out and en are registered outputs. d_out holds its last value when en=0.
- win_valid: 1 only on the k==FilterSize-1 cycle of a column whose captured col >= FilterSize-1. It is 0 for cols 0..FilterSize-2 of every row, because those windows span a line wrap.
- Exactly FilterSize en pulses per emitted column. A partial column is never emitted except when truncated by rst.
- A frame_start accept arriving during a primed stream causes no emission for that pixel (row=0).

Test Plan:
1. Reset, then feed 4 full rows (128 px, value = row*32+col), pix_valid held high -> en stays 0; pix_ready stays 1.
2. Feed row 4, col 0 (value 128) -> en high for 5 cycles with d_out = 0, 32, 64, 96, 128; win_valid=0.
3. Continue row 4 with pix_valid held high -> one accept every 5 cycles and en continuous. At col 4, the k=4 cycle shows d_out=132 and win_valid=1; win_valid stays 0 for cols 0..3.
4. Drop pix_valid for 3 cycles mid-row -> en falls after the current column completes and resumes 1 cycle after the next accept. No extra or missing en pulses (5 per column).
5. Assert rst during k=2 of an emission -> en=0 and d_out=0 the next cycle; pix_ready=1. The next 128 pixels produce no en (re-priming).
6. frame_start with pixel 7 during row 6 -> no en for that pixel. The following 127 pixels produce no en; en resumes only once row reaches 4 again.
